// File: rtl/bird_mem_pkg.sv
// Shared types and widths for the bird program/data memory subsystem
// (CPU, arbiter and memory model).
package bird_mem_pkg;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Two-master memory bus: per-port request/grant/read-return signals plus the
// single-port memory connection. The master side also supplies memory read data.
interface mem_arbiter_if;
  import bird_mem_pkg::*;

  logic          req0, req1;
  logic          we0, we1;
  logic          lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic          memwt;
  logic [DW-1:0] data_in;

  modport master (
    output req0, req1, we0, we1, lock0, lock1,
    output addr0, addr1, wdata0, wdata1,
    output data_in,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  address, data_out, memwt
  );

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1,
    input  addr0, addr1, wdata0, wdata1,
    input  data_in,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output address, data_out, memwt
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU (port 0)
// and a peripheral master (port 1), with bounded lock bursts.
module mem_arbiter
  import bird_mem_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus_io
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BurstLast = CW'(MAX_BURST - 1);

  arb_state_e    owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          gnt0, gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Memory-side mux and read-return capture.
  always_comb begin
    gnt0 = (owner_q == OWN0) && bus_io.req0;
    gnt1 = (owner_q == OWN1) && bus_io.req1;

    bus_io.gnt0     = gnt0;
    bus_io.gnt1     = gnt1;
    bus_io.address  = '0;
    bus_io.data_out = '0;
    bus_io.memwt    = 1'b0;
    if (gnt0) begin
      bus_io.address  = bus_io.addr0;
      bus_io.data_out = bus_io.wdata0;
      bus_io.memwt    = bus_io.we0;
    end else if (gnt1) begin
      bus_io.address  = bus_io.addr1;
      bus_io.data_out = bus_io.wdata1;
      bus_io.memwt    = bus_io.we1;
    end

    rvalid0_d = gnt0 && !bus_io.we0;
    rvalid1_d = gnt1 && !bus_io.we1;
    rdata0_d  = rvalid0_d ? bus_io.data_in : rdata0_q;
    rdata1_d  = rvalid1_d ? bus_io.data_in : rdata1_q;

    bus_io.rvalid0 = rvalid0_q;
    bus_io.rvalid1 = rvalid1_q;
    bus_io.rdata0  = rdata0_q;
    bus_io.rdata1  = rdata1_q;
  end

  // Ownership: a locked owner keeps the bus for at most MAX_BURST transfers
  // while the other port waits; otherwise ownership alternates on contention.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (owner_q)
      IDLE: begin
        cnt_d = '0;
        if (bus_io.req0 && bus_io.req1) owner_d = last_q ? OWN0 : OWN1;
        else if (bus_io.req0)           owner_d = OWN0;
        else if (bus_io.req1)           owner_d = OWN1;
      end
      OWN0: begin
        if (bus_io.req0 && bus_io.lock0 && (cnt_q < BurstLast)) begin
          cnt_d = cnt_q + CW'(1);
        end else if (bus_io.req1) begin
          owner_d = OWN1;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (bus_io.req0) begin
          cnt_d = (cnt_q < BurstLast) ? cnt_q + CW'(1) : BurstLast;
        end else begin
          owner_d = IDLE;
          last_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      OWN1: begin
        if (bus_io.req1 && bus_io.lock1 && (cnt_q < BurstLast)) begin
          cnt_d = cnt_q + CW'(1);
        end else if (bus_io.req0) begin
          owner_d = OWN0;
          last_d  = 1'b1;
          cnt_d   = '0;
        end else if (bus_io.req1) begin
          cnt_d = (cnt_q < BurstLast) ? cnt_q + CW'(1) : BurstLast;
        end else begin
          owner_d = IDLE;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: owner_d = IDLE;
    endcase
  end

endmodule
